// File: rtl/ram_arbiter.sv
// Two-master arbiter for a single-port data RAM: the CPU data port (m0) and a loader/DMA port (m1).
// Each grant lasts one cycle; RAM strobes and acks are decoded from the state register.
module ram_arbiter #(
    parameter int unsigned RR_EN = 1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [3:0]  m0_sel,
    input  logic [31:0] m0_data_i,
    output logic [31:0] m0_data_o,
    output logic        m0_ack,

    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [3:0]  m1_sel,
    input  logic [31:0] m1_data_i,
    output logic [31:0] m1_data_o,
    output logic        m1_ack,

    output logic        ram_ce_o,
    output logic        ram_we_o,
    output logic [31:0] ram_addr_o,
    output logic [3:0]  ram_sel_o,
    output logic [31:0] ram_data_o,
    input  logic [31:0] ram_data_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   last_grant_q, last_grant_d;
    logic   gnt0, gnt1;

    always_comb begin
        state_d = IDLE;
        unique case (state_q)
            IDLE: begin
                if (m0_req && m1_req) begin
                    // On a tie, round-robin favours whoever was not served last.
                    if ((RR_EN != 0) && !last_grant_q) state_d = GNT1;
                    else                               state_d = GNT0;
                end else if (m0_req) begin
                    state_d = GNT0;
                end else if (m1_req) begin
                    state_d = GNT1;
                end
            end
            // The granted master still holds req during its ack cycle, so only
            // the other master can chain a grant.
            GNT0:    state_d = m1_req ? GNT1 : IDLE;
            GNT1:    state_d = m0_req ? GNT0 : IDLE;
            default: state_d = IDLE;
        endcase

        last_grant_d = last_grant_q;
        if (state_d == GNT0) last_grant_d = 1'b0;
        if (state_d == GNT1) last_grant_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Async reset clears state_q, which drops every strobe below without a clock.
    assign gnt0 = (state_q == GNT0);
    assign gnt1 = (state_q == GNT1);

    assign ram_ce_o   = gnt0 | gnt1;
    assign ram_we_o   = (gnt0 & m0_we) | (gnt1 & m1_we);
    assign ram_addr_o = gnt0 ? m0_addr   : (gnt1 ? m1_addr   : 32'd0);
    assign ram_sel_o  = gnt0 ? m0_sel    : (gnt1 ? m1_sel    : 4'd0);
    assign ram_data_o = gnt0 ? m0_data_i : (gnt1 ? m1_data_i : 32'd0);

    assign m0_ack    = gnt0;
    assign m1_ack    = gnt1;
    assign m0_data_o = (gnt0 && !m0_we) ? ram_data_i : 32'd0;
    assign m1_data_o = (gnt1 && !m1_we) ? ram_data_i : 32'd0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: one round-robin and one fixed-priority instance, each on its own RAM.
// Table vectors, directed corner sequences, then random traffic against a rule-level model.
module tb_ram_arbiter;

    logic clk;
    logic rst;
    logic mem_clr;

    logic        req  [2][2];
    logic        we   [2][2];
    logic [31:0] addr [2][2];
    logic [3:0]  sel  [2][2];
    logic [31:0] wd   [2][2];
    logic [31:0] rd_o [2][2];
    logic        ack  [2][2];

    logic        ce    [2];
    logic        rwe   [2];
    logic [31:0] raddr [2];
    logic [3:0]  rsel  [2];
    logic [31:0] rwd   [2];
    logic [31:0] rrd   [2];

    logic [31:0] ram_mem [2][256];
    logic [31:0] exp_mem [2][256];

    int n_chk = 0;
    int n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ram_arbiter #(.RR_EN(1)) dut_rr (
        .clk(clk), .rst(rst),
        .m0_req(req[0][0]), .m0_we(we[0][0]), .m0_addr(addr[0][0]), .m0_sel(sel[0][0]),
        .m0_data_i(wd[0][0]), .m0_data_o(rd_o[0][0]), .m0_ack(ack[0][0]),
        .m1_req(req[0][1]), .m1_we(we[0][1]), .m1_addr(addr[0][1]), .m1_sel(sel[0][1]),
        .m1_data_i(wd[0][1]), .m1_data_o(rd_o[0][1]), .m1_ack(ack[0][1]),
        .ram_ce_o(ce[0]), .ram_we_o(rwe[0]), .ram_addr_o(raddr[0]), .ram_sel_o(rsel[0]),
        .ram_data_o(rwd[0]), .ram_data_i(rrd[0])
    );

    ram_arbiter #(.RR_EN(0)) dut_fp (
        .clk(clk), .rst(rst),
        .m0_req(req[1][0]), .m0_we(we[1][0]), .m0_addr(addr[1][0]), .m0_sel(sel[1][0]),
        .m0_data_i(wd[1][0]), .m0_data_o(rd_o[1][0]), .m0_ack(ack[1][0]),
        .m1_req(req[1][1]), .m1_we(we[1][1]), .m1_addr(addr[1][1]), .m1_sel(sel[1][1]),
        .m1_data_i(wd[1][1]), .m1_data_o(rd_o[1][1]), .m1_ack(ack[1][1]),
        .ram_ce_o(ce[1]), .ram_we_o(rwe[1]), .ram_addr_o(raddr[1]), .ram_sel_o(rsel[1]),
        .ram_data_o(rwd[1]), .ram_data_i(rrd[1])
    );

    // RAM environment: combinational read, byte-lane write on the edge ending the access.
    assign rrd[0] = ram_mem[0][raddr[0][9:2]];
    assign rrd[1] = ram_mem[1][raddr[1][9:2]];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mem_clr) begin
                for (int w = 0; w < 256; w++) ram_mem[i][w] <= 32'd0;
            end else if (ce[i] && rwe[i]) begin
                for (int b = 0; b < 4; b++)
                    if (rsel[i][b]) ram_mem[i][raddr[i][9:2]][8*b +: 8] <= rwd[i][8*b +: 8];
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_all();
        for (int i = 0; i < 2; i++)
            for (int m = 0; m < 2; m++) begin
                req[i][m] = 1'b0; we[i][m] = 1'b0; addr[i][m] = 32'd0;
                sel[i][m] = 4'd0; wd[i][m] = 32'd0;
            end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: grant for the coming cycle from last cycle's requests,
    // excluding whoever was granted last cycle (no back-to-back acks).
    function automatic int next_grant(input int g_prev, input bit r0, input bit r1,
                                      input int lw, input bit rr);
        bit c0, c1;
        c0 = r0 && (g_prev != 0);
        c1 = r1 && (g_prev != 1);
        if (c0 && c1) return rr ? (1 - lw) : 0;
        if (c0) return 0;
        if (c1) return 1;
        return -1;
    endfunction

    // Compare every output of instance i against the access of master gg (-1 = none).
    task automatic chk_inst(input int i, input int gg, input string tag);
        logic [3:0]  e_ctl;
        logic [3:0]  e_sel;
        logic [31:0] e_addr, e_wd;
        logic [31:0] e_do [2];
        e_ctl = 4'b0000; e_sel = 4'd0; e_addr = 32'd0; e_wd = 32'd0;
        e_do[0] = 32'd0; e_do[1] = 32'd0;
        if (gg >= 0) begin
            e_ctl  = {gg == 0, gg == 1, 1'b1, we[i][gg]};
            e_sel  = sel[i][gg];
            e_addr = addr[i][gg];
            e_wd   = wd[i][gg];
            if (!we[i][gg]) e_do[gg] = exp_mem[i][addr[i][gg][9:2]];
        end
        chk({tag, "_ctl"}, {ack[i][0], ack[i][1], ce[i], rwe[i], rsel[i]}, {e_ctl, e_sel});
        chk({tag, "_addr"}, raddr[i], e_addr);
        chk({tag, "_wdata"}, rwd[i], e_wd);
        chk({tag, "_do0"}, rd_o[i][0], e_do[0]);
        chk({tag, "_do1"}, rd_o[i][1], e_do[1]);
    endtask

    // One access from IDLE; checks ack latency and returns the data seen in the ack cycle.
    task automatic do_access(input int i, input int m, input bit w, input logic [31:0] a,
                             input logic [3:0] s, input logic [31:0] d,
                             output logic [31:0] rdata);
        int  lat;
        bit  got;
        lat = 99; got = 1'b0; rdata = 32'hx;
        req[i][m] = 1'b1; we[i][m] = w; addr[i][m] = a; sel[i][m] = s; wd[i][m] = d;
        for (int c = 0; c < 8 && !got; c++) begin
            @(negedge clk);
            if (ack[i][m]) begin
                got = 1'b1; lat = c; rdata = rd_o[i][m];
            end
            tick();
        end
        req[i][m] = 1'b0; we[i][m] = 1'b0;
        chk($sformatf("latency_i%0d_m%0d_a%0h", i, m, a), lat, 1);
    endtask

    typedef struct {
        bit r0, r1;
        bit a0_rr, a1_rr, a0_fp, a1_fp;
    } vec_t;

    vec_t tbl [16];
    logic [31:0] rdat;
    int   g [2];
    int   lw [2];
    bit   pending [2][2];
    bit   prev_ce;

    initial begin
        tbl[0]  = '{1, 1, 0, 0, 0, 0};
        tbl[1]  = '{1, 1, 1, 0, 1, 0};
        tbl[2]  = '{1, 1, 0, 1, 0, 1};
        tbl[3]  = '{1, 1, 1, 0, 1, 0};
        tbl[4]  = '{0, 0, 0, 1, 0, 1};
        tbl[5]  = '{0, 0, 0, 0, 0, 0};
        tbl[6]  = '{1, 1, 0, 0, 0, 0};
        tbl[7]  = '{0, 0, 1, 0, 1, 0};
        tbl[8]  = '{1, 1, 0, 0, 0, 0};
        tbl[9]  = '{0, 0, 0, 1, 1, 0};
        tbl[10] = '{0, 1, 0, 0, 0, 0};
        tbl[11] = '{1, 0, 0, 1, 0, 1};
        tbl[12] = '{1, 0, 1, 0, 1, 0};
        tbl[13] = '{1, 1, 0, 0, 0, 0};
        tbl[14] = '{0, 0, 0, 1, 1, 0};
        tbl[15] = '{0, 0, 0, 0, 0, 0};

        rst = 1'b1;
        mem_clr = 1'b1;
        idle_all();
        for (int i = 0; i < 2; i++)
            for (int m = 0; m < 2; m++) begin
                req[i][m] = 1'b1; we[i][m] = 1'b1; addr[i][m] = 32'h44; sel[i][m] = 4'hF;
                wd[i][m] = 32'h5555AAAA;
            end
        tick();
        for (int i = 0; i < 2; i++) chk_inst(i, -1, $sformatf("reset_i%0d", i));
        tick();
        mem_clr = 1'b0;

        // Table phase: both instances driven alike, reads of 0x40 (m0) and 0x44 (m1).
        idle_all();
        rst = 1'b0;
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 2; i++) begin
                req[i][0] = tbl[k].r0; req[i][1] = tbl[k].r1;
                addr[i][0] = 32'h40; addr[i][1] = 32'h44;
                sel[i][0] = 4'hF; sel[i][1] = 4'hF;
            end
            @(negedge clk);
            chk($sformatf("tbl%0d_rr_ack", k), {ack[0][0], ack[0][1]}, {tbl[k].a0_rr, tbl[k].a1_rr});
            chk($sformatf("tbl%0d_fp_ack", k), {ack[1][0], ack[1][1]}, {tbl[k].a0_fp, tbl[k].a1_fp});
            chk($sformatf("tbl%0d_rr_ce", k), ce[0], tbl[k].a0_rr | tbl[k].a1_rr);
            chk($sformatf("tbl%0d_fp_ce", k), ce[1], tbl[k].a0_fp | tbl[k].a1_fp);
            chk($sformatf("tbl%0d_rr_addr", k), raddr[0],
                tbl[k].a0_rr ? 32'h40 : (tbl[k].a1_rr ? 32'h44 : 32'h0));
            chk($sformatf("tbl%0d_fp_addr", k), raddr[1],
                tbl[k].a0_fp ? 32'h40 : (tbl[k].a1_fp ? 32'h44 : 32'h0));
            tick();
        end
        idle_all();
        tick();

        // m0 write then read back.
        do_access(0, 0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, rdat);
        do_access(0, 0, 1'b0, 32'h10, 4'hF, 32'h0, rdat);
        chk("m0_read_0x10", rdat, 32'hDEADBEEF);

        // m1 alone holding req: acks every other cycle, never back-to-back CE.
        req[0][1] = 1'b1; addr[0][1] = 32'h10; sel[0][1] = 4'hF;
        prev_ce = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("m1_alone_ack_c%0d", c), ack[0][1], c % 2);
            chk($sformatf("m1_alone_ce_pair_c%0d", c), prev_ce & ce[0], 1'b0);
            prev_ce = ce[0];
            tick();
        end
        req[0][1] = 1'b0;
        tick();

        // Byte-lane write over an all-ones word.
        do_access(0, 1, 1'b1, 32'h30, 4'hF, 32'hFFFFFFFF, rdat);
        do_access(0, 1, 1'b1, 32'h30, 4'b0010, 32'h0000AB00, rdat);
        do_access(0, 1, 1'b0, 32'h30, 4'hF, 32'h0, rdat);
        chk("m1_byte_merge", rdat, 32'hFFFFABFF);

        // Reset in the middle of a GNT1 write aborts it without a clock edge.
        do_access(0, 1, 1'b1, 32'h20, 4'hF, 32'hCAFEF00D, rdat);
        req[0][1] = 1'b1; we[0][1] = 1'b1; addr[0][1] = 32'h20; sel[0][1] = 4'hF;
        wd[0][1] = 32'h12345678;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("abort_ack_before_rst", {ack[0][1], ce[0]}, 2'b11);
        #1 rst = 1'b1;
        #1 chk("abort_async_drop", {ack[0][1], ce[0], rwe[0]}, 3'b000);
        #1 rst = 1'b0;
        req[0][1] = 1'b0; we[0][1] = 1'b0;
        tick();
        do_access(0, 1, 1'b0, 32'h20, 4'hF, 32'h0, rdat);
        chk("abort_no_write", rdat, 32'hCAFEF00D);

        // Fixed priority: m0 served last, then a tie goes to m0 again, m1 next cycle.
        do_access(1, 0, 1'b0, 32'h40, 4'hF, 32'h0, rdat);
        req[1][0] = 1'b1; addr[1][0] = 32'h50; sel[1][0] = 4'hF;
        req[1][1] = 1'b1; addr[1][1] = 32'h54; sel[1][1] = 4'hF;
        @(negedge clk);
        chk("fp_tie_c0", {ack[1][0], ack[1][1]}, 2'b00);
        tick();
        @(negedge clk);
        chk("fp_tie_c1", {ack[1][0], ack[1][1], raddr[1]}, {2'b10, 32'h50});
        tick();
        req[1][0] = 1'b0;
        @(negedge clk);
        chk("fp_tie_c2", {ack[1][0], ack[1][1], raddr[1]}, {2'b01, 32'h54});
        tick();
        req[1][1] = 1'b0;

        // Withdrawn request: m1 drops req before being served; its write never happens.
        req[1][0] = 1'b1; addr[1][0] = 32'h60; sel[1][0] = 4'hF;
        req[1][1] = 1'b1; we[1][1] = 1'b1; addr[1][1] = 32'h60; sel[1][1] = 4'hF;
        wd[1][1] = 32'h11111111;
        @(negedge clk);
        tick();
        req[1][1] = 1'b0; we[1][1] = 1'b0;
        @(negedge clk);
        chk("withdraw_c1", {ack[1][0], ack[1][1]}, 2'b10);
        tick();
        req[1][0] = 1'b0;
        @(negedge clk);
        chk("withdraw_c2", {ack[1][1], ce[1]}, 2'b00);
        tick();
        do_access(1, 0, 1'b0, 32'h60, 4'hF, 32'h0, rdat);
        chk("withdraw_no_write", rdat, 32'h0);

        // Random phase against the reference model, starting from a clean reset.
        rst = 1'b1;
        mem_clr = 1'b1;
        idle_all();
        for (int i = 0; i < 2; i++) begin
            g[i] = -1; lw[i] = 1;
            for (int w = 0; w < 256; w++) exp_mem[i][w] = 32'd0;
            for (int m = 0; m < 2; m++) pending[i][m] = 1'b0;
        end
        tick();
        rst = 1'b0;
        mem_clr = 1'b0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int i = 0; i < 2; i++)
                for (int m = 0; m < 2; m++) begin
                    if (!pending[i][m] && $urandom_range(0, 2) == 0) begin
                        pending[i][m] = 1'b1;
                        we[i][m]   = 1'($urandom_range(0, 1));
                        addr[i][m] = {22'd0, 8'($urandom), 2'b00};
                        sel[i][m]  = 4'($urandom);
                        wd[i][m]   = $urandom;
                    end
                    req[i][m] = pending[i][m];
                end
            @(negedge clk);
            for (int i = 0; i < 2; i++) chk_inst(i, g[i], $sformatf("rnd_i%0d", i));
            @(posedge clk);
            for (int i = 0; i < 2; i++) begin
                int gn;
                if (g[i] >= 0) begin
                    int mm;
                    mm = g[i];
                    if (we[i][mm])
                        for (int b = 0; b < 4; b++)
                            if (sel[i][mm][b])
                                exp_mem[i][addr[i][mm][9:2]][8*b +: 8] = wd[i][mm][8*b +: 8];
                    pending[i][mm] = 1'b0;
                end
                gn = next_grant(g[i], req[i][0], req[i][1], lw[i], i == 0);
                g[i] = gn;
                if (gn >= 0) lw[i] = gn;
            end
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter RR_EN, default 1: 1 = round-robin arbitration, 0 = fixed priority with m0 highest.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 m0_req  input  1  CPU data-port request; held high with qualifiers stable until m0_ack.
REQ-005 m0_we  input  1  write enable for the m0 access.
REQ-006 m0_addr  input  32  byte address for the m0 access.
REQ-007 m0_sel  input  4  byte-lane select for the m0 access.
REQ-008 m0_data_i  input  32  write data from m0.
REQ-009 m0_data_o  output  32  read data to m0.
REQ-010 m0_ack  output  1  one-cycle completion strobe to m0.
REQ-011 m1_req, m1_we, m1_addr[31:0], m1_sel[3:0], m1_data_i[31:0], m1_data_o[31:0], m1_ack SHALL be identical in direction, width and meaning to the m0 ports, for the loader/DMA master.
REQ-012 ram_ce_o  output  1  data RAM chip enable.
REQ-013 ram_we_o  output  1  data RAM write enable.
REQ-014 ram_addr_o  output  32  data RAM address.
REQ-015 ram_sel_o  output  4  data RAM byte select.
REQ-016 ram_data_o  output  32  data RAM write data.
REQ-017 ram_data_i  input  32  data RAM read data, combinational from the addressed word.

Function
REQ-018 FSM states SHALL be IDLE, GNT0 and GNT1, held in a state register; a last_grant register (1 bit) SHALL record the master granted most recently.
REQ-019 IDLE, no request: remain in IDLE.
REQ-020 IDLE, single request mx_req: go to GNTx.
REQ-021 IDLE, both requesting, RR_EN=1: grant the master that is not last_grant.
REQ-022 IDLE, both requesting, RR_EN=0: grant m0.
REQ-023 GNTx always lasts exactly one cycle; the next state SHALL be GNTy if the other master's req is high, else IDLE; the granted master's own req SHALL be ignored in this decision, because it is still high during its ack cycle.
REQ-024 On entry to GNTx, last_grant SHALL be set to x.
REQ-025 In GNTx: ram_ce_o=1, ram_we_o=mx_we, ram_addr_o=mx_addr, ram_sel_o=mx_sel, ram_data_o=mx_data_i, and mx_ack=1, all decoded from the state register plus the mx qualifiers.
REQ-026 In GNTx with mx_we=0: mx_data_o=ram_data_i in the same cycle as mx_ack; otherwise mx_data_o=0.
REQ-027 A write SHALL be committed by the RAM on the clock edge that ends the GNTx cycle.
REQ-028 In IDLE, all ram_* outputs and both acks SHALL be 0; a non-granted master's data_o and ack SHALL be 0.
REQ-029 Latency from an IDLE request to ack SHALL be 1 cycle (request in cycle N, ack in cycle N+1).
REQ-030 Throughput SHALL be 1 access per cycle when masters alternate, and 1 access per 2 cycles for a single master.
REQ-031 A master SHALL never receive two consecutive ack cycles.
REQ-032 A request dropped before its ack SHALL be treated as withdrawn, with no RAM access for it.
REQ-033 With both masters continuously requesting, grants SHALL strictly alternate in either RR_EN mode, because of REQ-023.

Reset
REQ-034 Asserting rst SHALL force state=IDLE and last_grant=1 immediately, without waiting for clk.
REQ-035 While rst is high, all outputs SHALL be 0.
REQ-036 Reset asserted during GNTx SHALL abort the access: ack and ram_ce_o drop asynchronously and no write is committed by the arbiter.
REQ-037 The first cycle after rst deasserts SHALL be IDLE; under RR_EN=1, m0 wins the first tie.

Verification
REQ-038 m0 write addr=0x10, sel=4'hF, data=0xDEADBEEF, then m0 read addr=0x10 -> ack one cycle after each req; read returns m0_data_o=0xDEADBEEF in its ack cycle.
REQ-039 RR_EN=1, both req high from reset release -> acks in order m0,m1,m0,m1 on consecutive cycles, with ram_addr_o following the granted master.
REQ-040 RR_EN=0, both request in IDLE after m0 was last granted -> m0 granted first, m1 next cycle.
REQ-041 m1 alone holds req for 6 cycles (req re-evaluated after each ack) -> m1_ack pattern 0,1,0,1,0,1, and ram_ce_o is never high two consecutive cycles.
REQ-042 rst pulsed mid-GNT1 write of 0x12345678 to 0x20 -> ack and ce drop without a clock edge; a later read of 0x20 returns the pre-existing value.
REQ-043 m1 byte write sel=4'b0010, data=0x0000AB00 over word 0xFFFFFFFF -> subsequent read returns 0xFFFFABFF.
